// File: rtl/hazard_scoreboard.sv
// Destination-tag scoreboard for the EX/MEM/WB stages. It supplies forwarding tags and
// raises stall/bubble controls for load-use hazards and for multi-cycle MDU occupancy of EX.
module hazard_scoreboard #(
  parameter int MDU_LATENCY = 4,
  parameter int REG_ADDR_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  id_mdu,
  input  logic                  flush_ex,
  output logic                  stall_if_id,
  output logic                  bubble_ex,
  output logic                  mdu_busy,
  output logic                  ex_valid,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_regwrite,
  output logic                  exmem_regwrite,
  output logic [REG_ADDR_W-1:0] exmem_rd,
  output logic                  memwb_regwrite,
  output logic [REG_ADDR_W-1:0] memwb_rd
);

  localparam int CNT_W = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;
  localparam logic [CNT_W-1:0] MDU_RELOAD = CNT_W'(MDU_LATENCY - 1);

  // EX is _p0, MEM is _p1, WB is _p2. Downstream of EX only {regwrite, rd} is observable.
  logic                  vld_p0;
  logic [REG_ADDR_W-1:0] rd_p0;
  logic                  wr_p0;
  logic                  ld_p0;
  logic [REG_ADDR_W-1:0] rd_p1;
  logic                  wr_p1;
  logic [REG_ADDR_W-1:0] rd_p2;
  logic                  wr_p2;
  logic [CNT_W-1:0]      mdu_cnt;

  logic busy;
  logic load_use;
  logic bubble_int;

  always_comb begin
    busy     = (mdu_cnt != '0);
    load_use = id_valid & vld_p0 & ld_p0 & wr_p0 &
               ((id_use_rs1 & (id_rs1 == rd_p0)) | (id_use_rs2 & (id_rs2 == rd_p0)));
    bubble_int = ~busy & (flush_ex | ~id_valid | load_use);
  end

  // Gated with rst so every control output reads 0 while reset is held.
  assign mdu_busy    = busy;
  assign stall_if_id = busy | (load_use & ~flush_ex);
  assign bubble_ex   = bubble_int & ~rst;

  // ---- ID -> EX (p0), EX -> MEM (p1), MEM -> WB (p2) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      rd_p0   <= '0;
      wr_p0   <= 1'b0;
      ld_p0   <= 1'b0;
      rd_p1   <= '0;
      wr_p1   <= 1'b0;
      rd_p2   <= '0;
      wr_p2   <= 1'b0;
      mdu_cnt <= '0;
    end else if (busy) begin
      rd_p1   <= '0;
      wr_p1   <= 1'b0;
      rd_p2   <= rd_p1;
      wr_p2   <= wr_p1;
      mdu_cnt <= mdu_cnt - CNT_W'(1);
    end else begin
      rd_p1 <= rd_p0;
      wr_p1 <= wr_p0;
      rd_p2 <= rd_p1;
      wr_p2 <= wr_p1;
      if (bubble_int) begin
        vld_p0 <= 1'b0;
        rd_p0  <= '0;
        wr_p0  <= 1'b0;
        ld_p0  <= 1'b0;
      end else begin
        vld_p0 <= 1'b1;
        rd_p0  <= id_rd;
        wr_p0  <= id_regwrite & (id_rd != '0);
        ld_p0  <= id_memread;
        if (id_mdu) mdu_cnt <= MDU_RELOAD;
      end
    end
  end

  assign ex_valid       = vld_p0;
  assign ex_rd          = rd_p0;
  assign ex_regwrite    = wr_p0;
  assign exmem_regwrite = wr_p1;
  assign exmem_rd       = rd_p1;
  assign memwb_regwrite = wr_p2;
  assign memwb_rd       = rd_p2;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer side of the operand-forwarding interface. Tracks destination tags of in-flight instructions through the EX, MEM and WB stages.
- Drives the exmem_* and memwb_* tag signals that the forwarding logic compares against rs1_ex/rs2_ex.
- Detects the hazards that forwarding cannot cover and raises stall and bubble controls: load-use, and multi-cycle MDU (mul/div) occupancy of EX.

Parameters:
- MDU_LATENCY, 4, total cycles an MDU instruction occupies EX (>=1; 1 means no hold).
- REG_ADDR_W, 5, register address width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs1  input  REG_ADDR_W  source register 1 of ID instruction.
- id_rs2  input  REG_ADDR_W  source register 2 of ID instruction.
- id_use_rs1  input  1  ID instruction reads rs1.
- id_use_rs2  input  1  ID instruction reads rs2.
- id_rd  input  REG_ADDR_W  destination of ID instruction.
- id_regwrite  input  1  ID instruction writes rd.
- id_memread  input  1  ID instruction is a load.
- id_mdu  input  1  ID instruction is a multi-cycle MDU op.
- flush_ex  input  1  squash the instruction leaving ID this cycle (branch redirect).
- stall_if_id  output  1  hold PC and IF/ID register (combinational).
- bubble_ex  output  1  EX receives a bubble at the next edge (combinational).
- mdu_busy  output  1  MDU op held in EX (combinational from counter).
- ex_valid  output  1  EX stage tag valid (registered).
- ex_rd  output  REG_ADDR_W  EX destination (registered).
- ex_regwrite  output  1  EX writes rd (registered).
- exmem_regwrite  output  1  MEM stage writes rd (registered).
- exmem_rd  output  REG_ADDR_W  MEM destination (registered).
- memwb_regwrite  output  1  WB stage writes rd (registered).
- memwb_rd  output  REG_ADDR_W  WB destination (registered).

Behaviour:
- Stage entries:
  - EX, MEM and WB each hold {valid, rd, regwrite, memread, mdu}.
  - A bubble is all-zero.
  - regwrite is captured as id_regwrite & (id_rd != 0), so x0 is never a forwarding source.
- Reset (async, immediate): all stage entries zero; mdu_cnt = 0.
  - All outputs are 0 during reset, including stall_if_id, bubble_ex and mdu_busy.
  - Reset mid-MDU-hold aborts the hold.
- mdu_busy = (mdu_cnt != 0).
- load_use is asserted when all of the following hold:
  - id_valid, EX.valid, EX.memread and EX.regwrite;
  - and either (id_use_rs1 & id_rs1 == EX.rd) or (id_use_rs2 & id_rs2 == EX.rd).
- stall_if_id = mdu_busy | (load_use & ~flush_ex).
- bubble_ex = ~mdu_busy & (flush_ex | ~id_valid | load_use).
- Per-edge update, evaluated in priority order:
  1. mdu_busy: EX holds its entry. MEM <= bubble; WB <= MEM; mdu_cnt decrements. flush_ex is ignored.
  2. else bubble_ex: EX <= bubble; MEM <= EX; WB <= MEM.
  3. else: EX <= ID fields; MEM <= EX; WB <= MEM.
- MDU counter:
  - When an id_mdu instruction enters EX (case 3), mdu_cnt <= MDU_LATENCY-1.
  - The op therefore occupies EX for exactly MDU_LATENCY cycles, then advances to MEM.
  - With MDU_LATENCY=1 the counter stays 0 and there is never a hold.
- Consecutive MDU ops: the second enters EX on the cycle the first advances, then reloads the counter. No idle cycle between them.
- Load followed by dependent load: one bubble, then normal flow. The MEM/WB-stage load result is forwarded externally.
- Dependencies on EX non-load, MEM or WB producers do not stall; forwarding covers them.
- ex_*, exmem_* and memwb_* outputs are direct register outputs. exmem_*/memwb_* match MEM/WB {regwrite, rd}.

Test Plan:
- Reset, then ADD x5 (rd=5, regwrite) issued with no hazards -> ex_rd=5 at cycle 1, exmem_rd=5 at cycle 2, memwb_rd=5 at cycle 3. stall_if_id=0 throughout.
- Load rd=7 in EX and ID reads rs1=7 with use_rs1=1 -> stall_if_id=1 and bubble_ex=1 for one cycle. Next cycle exmem_rd=7 with exmem_regwrite=1 and the dependent instruction enters EX.
- Same load-use case with flush_ex=1 -> stall_if_id=0, bubble_ex=1, no held instruction. Also: load to rd=0 with ID reading x0 -> no stall, and exmem_regwrite=0 when it reaches MEM.
- MDU op rd=9 with MDU_LATENCY=4 -> mdu_busy=1 for 3 cycles and EX holds rd=9 over 4 edges, with exmem_regwrite=0 on the 3 hold cycles. Then exmem_rd=9; two back-to-back MDU ops complete 4 cycles apart.
- Assert rst during the second MDU hold cycle -> all outputs 0 immediately and mdu_busy=0. After release, a new ADD flows with latency 1/2/3 as in scenario 1.
- Rebuild with MDU_LATENCY=1 and issue an MDU op -> mdu_busy never asserts and the op passes EX in one cycle.
